// File: rtl/enciende_led.sv
// enciende_led: LED reaction-game round controller.
// Waits a pseudo-random dark time and then lights one LED. It judges the player's
// press or the LED-off timeout, and keeps saturating hit and miss counters.
// The game ends once the miss count reaches MAX_ERRORS.
module enciende_led #(
  parameter int unsigned N_LEDS         = 4,
  parameter int unsigned MIN_WAIT       = 500,
  parameter int unsigned WAIT_SPAN_BITS = 10,
  parameter int unsigned SCORE_W        = 8,
  parameter int unsigned MAX_ERRORS     = 3
) (
  input  logic               clock1k,
  input  logic               reset,
  input  logic               start,
  input  logic [N_LEDS-1:0]  botones,
  input  logic               apagar,
  output logic [N_LEDS-1:0]  leds,
  output logic               led_encendido,
  output logic               acierto,
  output logic               fallo,
  output logic [SCORE_W-1:0] puntos,
  output logic [SCORE_W-1:0] errores,
  output logic               jugando
);

  localparam int unsigned IDX_W     = $clog2(N_LEDS);
  localparam int unsigned SPAN_MASK = (1 << WAIT_SPAN_BITS) - 1;
  localparam int unsigned MAX_WAIT  = MIN_WAIT + SPAN_MASK;
  localparam int unsigned CNT_W     = $clog2(MAX_WAIT + 1);
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_LIT     = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t             r_state;
  logic [15:0]        r_lfsr;
  logic [CNT_W-1:0]   r_wait_cnt;
  logic [N_LEDS-1:0]  r_leds;
  logic               r_led_on;
  logic               r_acierto;
  logic               r_fallo;
  logic [SCORE_W-1:0] r_puntos;
  logic [SCORE_W-1:0] r_errores;
  logic               r_jugando;

  state_t             w_state_nx;
  logic [CNT_W-1:0]   w_wait_cnt_nx;
  logic [N_LEDS-1:0]  w_leds_nx;
  logic               w_acierto_nx;
  logic               w_fallo_nx;
  logic [SCORE_W-1:0] w_puntos_nx;
  logic [SCORE_W-1:0] w_errores_nx;

  logic               w_lfsr_fb;
  logic [15:0]        w_lfsr_nx;
  logic [CNT_W-1:0]   w_wait_load;
  logic [N_LEDS-1:0]  w_lit_onehot;
  logic               w_wrong_press;
  logic               w_right_press;
  logic               w_released;
  logic               w_game_over;
  logic [SCORE_W-1:0] w_puntos_inc;
  logic [SCORE_W-1:0] w_errores_inc;

  // Right-shifting Fibonacci LFSR, taps 16,14,13,11; the seed keeps it out of the all-zero lock-up
  assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
  assign w_lfsr_nx = {w_lfsr_fb, r_lfsr[15:1]};

  // Dark time loaded when entering WAIT; the mask gives zero extra wait when the span is zero
  assign w_wait_load  = CNT_W'(MIN_WAIT) + CNT_W'(r_lfsr & 16'(SPAN_MASK));
  assign w_lit_onehot = N_LEDS'(1) << r_lfsr[IDX_W-1:0];

  // Press classification against the currently lit LED
  assign w_wrong_press = |(botones & ~r_leds);
  assign w_right_press = (botones == r_leds);
  assign w_released    = (botones == '0) && !apagar;
  assign w_game_over   = (r_errores >= SCORE_W'(MAX_ERRORS));

  // Saturating counter increments
  assign w_puntos_inc  = (r_puntos  == '1) ? r_puntos  : r_puntos  + SCORE_W'(1);
  assign w_errores_inc = (r_errores == '1) ? r_errores : r_errores + SCORE_W'(1);

  // Next-state and next-output logic
  always_comb begin
    w_state_nx    = r_state;
    w_wait_cnt_nx = r_wait_cnt;
    w_leds_nx     = '0;
    w_acierto_nx  = 1'b0;
    w_fallo_nx    = 1'b0;
    w_puntos_nx   = r_puntos;
    w_errores_nx  = r_errores;

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_puntos_nx   = '0;
          w_errores_nx  = '0;
          w_wait_cnt_nx = w_wait_load;
          w_state_nx    = S_WAIT;
        end
      end

      S_WAIT: begin
        if (r_wait_cnt <= CNT_W'(1)) begin
          w_leds_nx  = w_lit_onehot;
          w_state_nx = S_LIT;
        end else begin
          w_wait_cnt_nx = r_wait_cnt - CNT_W'(1);
        end
      end

      S_LIT: begin
        w_leds_nx = r_leds;
        if (w_wrong_press) begin
          w_leds_nx    = '0;
          w_fallo_nx   = 1'b1;
          w_errores_nx = w_errores_inc;
          w_state_nx   = S_RELEASE;
        end else if (w_right_press) begin
          w_leds_nx    = '0;
          w_acierto_nx = 1'b1;
          w_puntos_nx  = w_puntos_inc;
          w_state_nx   = S_RELEASE;
        end else if (apagar) begin
          w_leds_nx    = '0;
          w_fallo_nx   = 1'b1;
          w_errores_nx = w_errores_inc;
          w_state_nx   = S_RELEASE;
        end
      end

      S_RELEASE: begin
        if (w_released) begin
          if (w_game_over) begin
            w_state_nx = S_IDLE;
          end else begin
            w_wait_cnt_nx = w_wait_load;
            w_state_nx    = S_WAIT;
          end
        end
      end

      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // State, LFSR and registered outputs
  always_ff @(posedge clock1k or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_lfsr     <= LFSR_SEED;
      r_wait_cnt <= '0;
      r_leds     <= '0;
      r_led_on   <= 1'b0;
      r_acierto  <= 1'b0;
      r_fallo    <= 1'b0;
      r_puntos   <= '0;
      r_errores  <= '0;
      r_jugando  <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_lfsr     <= w_lfsr_nx;
      r_wait_cnt <= w_wait_cnt_nx;
      r_leds     <= w_leds_nx;
      r_led_on   <= |w_leds_nx;
      r_acierto  <= w_acierto_nx;
      r_fallo    <= w_fallo_nx;
      r_puntos   <= w_puntos_nx;
      r_errores  <= w_errores_nx;
      r_jugando  <= (w_state_nx != S_IDLE);
    end
  end

  assign leds          = r_leds;
  assign led_encendido = r_led_on;
  assign acierto       = r_acierto;
  assign fallo         = r_fallo;
  assign puntos        = r_puntos;
  assign errores       = r_errores;
  assign jugando       = r_jugando;

endmodule
